// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: resolves ALU operands through two forwarding paths,
// detects load-use hazards, and registers the issued instruction for EX.
//
// state   | meaning
// --------+--------------------------------------------------
// S_EMPTY | no valid instruction held, out_valid=0
// S_FULL  | instruction issued last edge, out_valid=1
// S_HOLD  | instruction held under downstream stall
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   input  logic [REG_W-1:0]  in_src_a,
   input  logic [REG_W-1:0]  in_src_b,
   input  logic [REG_W-1:0]  in_dst,
   input  logic              in_wr_en,
   input  logic [3:0]        in_alu_ctrl,
   input  logic              stall,
   input  logic              flush,
   input  logic              fw1_valid,
   input  logic              fw1_is_load,
   input  logic [REG_W-1:0]  fw1_dst,
   input  logic [DATA_W-1:0] fw1_data,
   input  logic              fw2_valid,
   input  logic [REG_W-1:0]  fw2_dst,
   input  logic [DATA_W-1:0] fw2_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [3:0]        out_alu_ctrl,
   output logic [REG_W-1:0]  out_dst,
   output logic              out_wr_en,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FULL  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic              hazard;
   logic              accept;
   logic              load_en;
   logic              valid_nxt;
   logic [DATA_W-1:0] opa, opb;

   // Load-use hazard: the EX/MEM load result is not yet available for forwarding.
   assign hazard = in_valid & fw1_valid & fw1_is_load & (fw1_dst != '0) &
                   ((fw1_dst == in_src_a) | (~in_use_imm & (fw1_dst == in_src_b)));
   assign in_ready = ~stall & ~hazard;
   assign accept   = in_valid & in_ready;

   // Operand resolution; register 0 is hardwired and never forwarded.
   always_comb begin
      opa = in_a;
      if (in_src_a != '0 && fw1_valid && fw1_dst == in_src_a)
         opa = fw1_data;
      else if (in_src_a != '0 && fw2_valid && fw2_dst == in_src_a)
         opa = fw2_data;

      opb = in_b;
      if (in_use_imm)
         opb = in_imm;
      else if (in_src_b != '0 && fw1_valid && fw1_dst == in_src_b)
         opb = fw1_data;
      else if (in_src_b != '0 && fw2_valid && fw2_dst == in_src_b)
         opb = fw2_data;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_EMPTY;
      else        state <= state_nxt;
   end

   // Next-state logic; flush outranks stall, stall outranks accept.
   always_comb begin
      state_nxt = S_EMPTY;
      if (flush)
         state_nxt = S_EMPTY;
      else if (stall)
         state_nxt = (state == S_EMPTY) ? S_EMPTY : S_HOLD;
      else if (accept)
         state_nxt = S_FULL;
   end

   // Output control derived from the transition being taken.
   always_comb begin
      load_en   = (state_nxt == S_FULL);
      valid_nxt = (state_nxt != S_EMPTY);
   end

   // Registered outputs; payload holds in EMPTY and HOLD, wr_en drops in EMPTY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_a        <= '0;
         out_b        <= '0;
         out_alu_ctrl <= '0;
         out_dst      <= '0;
         out_wr_en    <= 1'b0;
      end else begin
         out_valid <= valid_nxt;
         if (load_en) begin
            out_a        <= opa;
            out_b        <= opb;
            out_alu_ctrl <= in_alu_ctrl;
            out_dst      <= in_dst;
            out_wr_en    <= in_wr_en;
         end else if (!valid_nxt) begin
            out_wr_en    <= 1'b0;
         end
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall && out_valid && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (hazard && !stall && !flush && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int RW = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, in_use_imm, in_wr_en;
   logic [DW-1:0] in_a, in_b, in_imm;
   logic [RW-1:0] in_src_a, in_src_b, in_dst;
   logic [3:0]    in_alu_ctrl;
   logic          stall, flush;
   logic          fw1_valid, fw1_is_load, fw2_valid;
   logic [RW-1:0] fw1_dst, fw2_dst;
   logic [DW-1:0] fw1_data, fw2_data;
   logic          out_valid, out_wr_en;
   logic [DW-1:0] out_a, out_b;
   logic [3:0]    out_alu_ctrl;
   logic [RW-1:0] out_dst;
   logic [CW-1:0] stall_cnt, bubble_cnt;

   int checks = 0;
   int passes = 0;

   // model state
   logic          m_valid, m_wr;
   logic [DW-1:0] m_a, m_b;
   logic [3:0]    m_ctrl;
   logic [RW-1:0] m_dst;
   int            m_stall, m_bubble;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_use_imm(in_use_imm),
      .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dst(in_dst),
      .in_wr_en(in_wr_en), .in_alu_ctrl(in_alu_ctrl),
      .stall(stall), .flush(flush),
      .fw1_valid(fw1_valid), .fw1_is_load(fw1_is_load),
      .fw1_dst(fw1_dst), .fw1_data(fw1_data),
      .fw2_valid(fw2_valid), .fw2_dst(fw2_dst), .fw2_data(fw2_data),
      .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
      .out_alu_ctrl(out_alu_ctrl), .out_dst(out_dst), .out_wr_en(out_wr_en),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   function automatic logic model_hazard();
      return in_valid && fw1_valid && fw1_is_load && fw1_dst != 0 &&
             (fw1_dst == in_src_a || (!in_use_imm && fw1_dst == in_src_b));
   endfunction

   function automatic logic [DW-1:0] model_operand(input logic [RW-1:0] src,
                                                   input logic [DW-1:0] raw);
      if (src == 0) return raw;
      if (fw1_valid && fw1_dst == src) return fw1_data;
      if (fw2_valid && fw2_dst == src) return fw2_data;
      return raw;
   endfunction

   function automatic logic [105:0] exp_vec();
      logic [CW-1:0] sc, bc;
      sc = CW'(m_stall);
      bc = CW'(m_bubble);
      return {m_valid, m_a, m_b, m_ctrl, m_dst, m_wr, sc, bc};
   endfunction

   function automatic logic [105:0] dut_vec();
      return {out_valid, out_a, out_b, out_alu_ctrl, out_dst, out_wr_en,
              stall_cnt, bubble_cnt};
   endfunction

   task automatic model_reset();
      m_valid = 0; m_wr = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_dst = 0;
      m_stall = 0; m_bubble = 0;
   endtask

   // Advance the model by one edge using the inputs currently applied.
   task automatic model_edge();
      logic hz;
      hz = model_hazard();
      if (stall && m_valid && m_stall < 65535) m_stall++;
      if (hz && !stall && !flush && m_bubble < 65535) m_bubble++;
      if (flush) begin
         m_valid = 0; m_wr = 0;
      end else if (stall) begin
         // held or still empty: nothing changes
      end else if (in_valid && !hz) begin
         m_valid = 1;
         m_a     = model_operand(in_src_a, in_a);
         m_b     = in_use_imm ? in_imm : model_operand(in_src_b, in_b);
         m_ctrl  = in_alu_ctrl;
         m_dst   = in_dst;
         m_wr    = in_wr_en;
      end else begin
         m_valid = 0; m_wr = 0;
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = 0; in_a = 0; in_b = 0; in_imm = 0; in_use_imm = 0;
      in_src_a = 0; in_src_b = 0; in_dst = 0; in_wr_en = 0; in_alu_ctrl = 0;
      stall = 0; flush = 0;
      fw1_valid = 0; fw1_is_load = 0; fw1_dst = 0; fw1_data = 0;
      fw2_valid = 0; fw2_dst = 0; fw2_data = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      model_reset();
      #12;
      checks++;
      if (dut_vec() !== 106'd0)
         $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 106'd0);
      else passes++;
      rst_n = 1;
      #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready);
      else passes++;
   endtask

   task automatic test_plain_issue();
      clear_inputs();
      in_valid = 1; in_a = 5; in_b = 7; in_alu_ctrl = 4'b1110;
      in_src_a = 1; in_src_b = 2; in_dst = 6; in_wr_en = 1;
      cycle();
      checks++;
      if ({out_valid, out_a, out_b, out_alu_ctrl} !== {1'b1, 32'd5, 32'd7, 4'b1110})
         $display("FAIL plain_issue: got v=%b a=%0d b=%0d c=%b expected v=1 a=5 b=7 c=1110",
                  out_valid, out_a, out_b, out_alu_ctrl);
      else passes++;
      checks++;
      if (dut_vec() !== exp_vec())
         $display("FAIL plain_issue_model: got %h expected %h", dut_vec(), exp_vec());
      else passes++;
   endtask

   task automatic test_forward_priority();
      clear_inputs();
      in_valid = 1; in_src_a = 3; in_a = 32'h11;
      fw1_valid = 1; fw1_dst = 3; fw1_data = 32'hAA;
      fw2_valid = 1; fw2_dst = 3; fw2_data = 32'hBB;
      cycle();
      checks++;
      if (out_a !== 32'hAA) $display("FAIL fwd_fw1: got %h expected aa", out_a);
      else passes++;
      fw1_valid = 0;
      cycle();
      checks++;
      if (out_a !== 32'hBB) $display("FAIL fwd_fw2: got %h expected bb", out_a);
      else passes++;
      fw2_valid = 0;
      cycle();
      checks++;
      if (out_a !== 32'h11) $display("FAIL fwd_none: got %h expected 11", out_a);
      else passes++;
   endtask

   task automatic test_load_use();
      clear_inputs();
      in_valid = 1; in_src_a = 1; in_src_b = 4; in_b = 9;
      fw1_valid = 1; fw1_is_load = 1; fw1_dst = 4; fw1_data = 32'h44;
      #1;
      checks++;
      if (in_ready !== 1'b0) $display("FAIL load_use_ready: got %b expected 0", in_ready);
      else passes++;
      cycle();
      checks++;
      if ({out_valid, bubble_cnt} !== {1'b0, 16'd1})
         $display("FAIL load_use_bubble: got v=%b bubble=%0d expected v=0 bubble=1",
                  out_valid, bubble_cnt);
      else passes++;
      in_use_imm = 1; in_imm = 32'h77;
      #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL load_use_imm_ready: got %b expected 1", in_ready);
      else passes++;
      cycle();
      checks++;
      if ({out_valid, out_b, bubble_cnt} !== {1'b1, 32'h77, 16'd1})
         $display("FAIL load_use_imm_issue: got v=%b b=%h bubble=%0d expected v=1 b=77 bubble=1",
                  out_valid, out_b, bubble_cnt);
      else passes++;
   endtask

   task automatic test_reg0();
      clear_inputs();
      in_valid = 1; in_src_a = 0; in_a = 32'h12;
      fw1_valid = 1; fw1_dst = 0; fw1_data = 32'hFF;
      fw2_valid = 1; fw2_dst = 0; fw2_data = 32'hEE;
      cycle();
      checks++;
      if (out_a !== 32'h12) $display("FAIL reg0: got %h expected 12", out_a);
      else passes++;
   endtask

   task automatic test_stall_flush();
      logic [105:0] frozen;
      clear_inputs();
      in_valid = 1; in_a = 32'h100; in_b = 32'h200; in_dst = 5; in_wr_en = 1;
      in_alu_ctrl = 4'd3;
      cycle();
      frozen = dut_vec();
      stall = 1; in_a = 32'hDEAD; in_dst = 9;
      #1;
      checks++;
      if (in_ready !== 1'b0) $display("FAIL stall_ready: got %b expected 0", in_ready);
      else passes++;
      for (int i = 0; i < 3; i++) cycle();
      checks++;
      if (dut_vec() !== {frozen[105:32], 16'd3, frozen[15:0]})
         $display("FAIL stall_frozen: got %h expected %h", dut_vec(),
                  {frozen[105:32], 16'd3, frozen[15:0]});
      else passes++;
      flush = 1;
      cycle();
      checks++;
      if ({out_valid, out_wr_en} !== 2'b00)
         $display("FAIL flush_stall: got v=%b wr=%b expected 0 0", out_valid, out_wr_en);
      else passes++;
      checks++;
      if (dut_vec() !== exp_vec())
         $display("FAIL flush_stall_model: got %h expected %h", dut_vec(), exp_vec());
      else passes++;
   endtask

   task automatic test_reset_mid_hold();
      clear_inputs();
      in_valid = 1; in_a = 32'h55;
      cycle();
      stall = 1;
      cycle();
      #2;
      rst_n = 0;
      #1;
      checks++;
      if (dut_vec() !== 106'd0)
         $display("FAIL reset_mid_hold: got %h expected 0", dut_vec());
      else passes++;
      model_reset();
      @(negedge clk);
      rst_n = 1;
      clear_inputs();
      in_valid = 1; in_a = 32'h66; in_wr_en = 1;
      cycle();
      checks++;
      if ({out_valid, out_a, out_wr_en} !== {1'b1, 32'h66, 1'b1})
         $display("FAIL post_reset_accept: got v=%b a=%h wr=%b expected v=1 a=66 wr=1",
                  out_valid, out_a, out_wr_en);
      else passes++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         in_valid    = ($urandom_range(0, 9) < 8);
         in_a        = $urandom; in_b = $urandom; in_imm = $urandom;
         in_use_imm  = $urandom_range(0, 1);
         in_src_a    = RW'($urandom_range(0, 3));
         in_src_b    = RW'($urandom_range(0, 3));
         in_dst      = RW'($urandom);
         in_wr_en    = $urandom_range(0, 1);
         in_alu_ctrl = 4'($urandom);
         stall       = ($urandom_range(0, 3) == 0);
         flush       = ($urandom_range(0, 9) == 0);
         fw1_valid   = $urandom_range(0, 1);
         fw1_is_load = ($urandom_range(0, 2) == 0);
         fw1_dst     = RW'($urandom_range(0, 3));
         fw1_data    = $urandom;
         fw2_valid   = $urandom_range(0, 1);
         fw2_dst     = RW'($urandom_range(0, 3));
         fw2_data    = $urandom;
         #1;
         checks++;
         if (in_ready !== (!stall && !model_hazard()))
            $display("FAIL rand_ready[%0d]: got %b expected %b", n, in_ready,
                     (!stall && !model_hazard()));
         else passes++;
         cycle();
         checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL rand_out[%0d]: got %h expected %h", n, dut_vec(), exp_vec());
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_plain_issue();
      test_forward_priority();
      test_load_use();
      test_reg0();
      test_stall_flush();
      test_reset_mid_hold();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
